wb_stage_buf: RTL and testbench

- Parametrised write-back stage placed between the MEM/WB pipeline register and the register-file write port.
- Formats load data by width, sign and byte offset, then selects the write-back source (ALU result, load data or PC+4).
- Buffers retiring instructions in a SKID_DEPTH FIFO so the register-file port can stall without losing results.
- Provides forwarding of the oldest pending result and a retired-instruction counter.

---
 rtl/wb_stage_buf.sv | 154 +++++++++++++++
 tb/tb_wb_stage_buf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buf.sv
// Write-back stage: formats load data, selects the write-back source and
// buffers retiring results in a small skid FIFO ahead of the register file.
module wb_stage_buf #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [XLEN-1:0]                 alu_result_in,
    input  logic [XLEN-1:0]                 load_data_in,
    input  logic [XLEN-1:0]                 pc_plus4_in,
    input  logic [AW-1:0]                   rd_addr_in,
    input  logic                            reg_write_en_in,
    input  logic [1:0]                      mem_to_reg_in,
    input  logic [2:0]                      load_funct3_in,
    input  logic [$clog2(XLEN/8)-1:0]       load_off_in,
    input  logic                            rf_ready,
    output logic                            rf_we,
    output logic [AW-1:0]                   rf_waddr,
    output logic [XLEN-1:0]                 rf_wdata,
    output logic                            fwd_valid,
    output logic [AW-1:0]                   fwd_rd,
    output logic [XLEN-1:0]                 fwd_data,
    output logic                            align_err,
    output logic [CNT_W-1:0]                retired_count
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);
    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] load_fmt;
    logic            fmt_err;
    logic            misalign;
    logic [XLEN-1:0] wb_data;
    logic            wb_err;
    logic            wb_wen;

    logic [XLEN-1:0] data_q [SKID_DEPTH];
    logic [AW-1:0]   rd_q   [SKID_DEPTH];
    logic            wen_q  [SKID_DEPTH];
    logic            err_q  [SKID_DEPTH];

    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            head_wen;
    logic            head_err;

    // Load formatting by width, signedness and byte offset
    always_comb begin
        sh       = load_data_in >> {load_off_in, 3'b000};
        load_fmt = '0;
        fmt_err  = 1'b0;
        misalign = 1'b0;
        case (load_funct3_in)
            3'b000: load_fmt = XLEN'($signed(sh[7:0]));
            3'b100: load_fmt = XLEN'(sh[7:0]);
            3'b001: begin
                load_fmt = XLEN'($signed(sh[15:0]));
                misalign = load_off_in[0];
            end
            3'b101: begin
                load_fmt = XLEN'(sh[15:0]);
                misalign = load_off_in[0];
            end
            3'b010: begin
                load_fmt = XLEN'($signed(sh[31:0]));
                misalign = (load_off_in[1:0] != 2'b00);
            end
            3'b110: begin
                load_fmt = XLEN'(sh[31:0]);
                misalign = (load_off_in[1:0] != 2'b00);
            end
            3'b011: begin
                if (XLEN == 64) begin
                    load_fmt = sh;
                    misalign = (load_off_in != OFF_W'(0));
                end else begin
                    fmt_err = 1'b1;
                end
            end
            default: fmt_err = 1'b1;
        endcase
    end

    // Write-back source select; load errors only matter when load data is chosen
    always_comb begin
        wb_data = '0;
        wb_err  = 1'b0;
        case (mem_to_reg_in)
            2'b00: wb_data = alu_result_in;
            2'b01: begin
                wb_data = load_fmt;
                wb_err  = fmt_err | misalign;
            end
            2'b10: wb_data = pc_plus4_in;
            default: wb_data = '0;
        endcase
        wb_wen = reg_write_en_in && (rd_addr_in != AW'(0)) && !wb_err;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head_wen = wen_q[rd_ptr[PTR_W-1:0]];
    assign head_err = err_q[rd_ptr[PTR_W-1:0]];
    assign pop      = !empty && (rf_ready || !head_wen);

    assign rf_we     = !empty && head_wen;
    assign rf_waddr  = rd_q[rd_ptr[PTR_W-1:0]];
    assign rf_wdata  = data_q[rd_ptr[PTR_W-1:0]];
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

    // Entry storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr[PTR_W-1:0]] <= wb_data;
            rd_q[wr_ptr[PTR_W-1:0]]   <= rd_addr_in;
            wen_q[wr_ptr[PTR_W-1:0]]  <= wb_wen;
            err_q[wr_ptr[PTR_W-1:0]]  <= wb_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            align_err     <= 1'b0;
            retired_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + (PTR_W + 1)'(1);
                retired_count <= retired_count + CNT_W'(1);
            end
            align_err <= pop && head_err;
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf (XLEN=32, SKID_DEPTH=2) with hand-computed
// expected values.
module tb_wb_stage_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_in;
    logic [31:0] load_data_in;
    logic [31:0] pc_plus4_in;
    logic [4:0]  rd_addr_in;
    logic        reg_write_en_in;
    logic [1:0]  mem_to_reg_in;
    logic [2:0]  load_funct3_in;
    logic [1:0]  load_off_in;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        align_err;
    logic [31:0] retired_count;

    int checks;
    int errors;

    wb_stage_buf #(.XLEN(32), .AW(5), .SKID_DEPTH(2), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_result_in   (alu_result_in),
        .load_data_in    (load_data_in),
        .pc_plus4_in     (pc_plus4_in),
        .rd_addr_in      (rd_addr_in),
        .reg_write_en_in (reg_write_en_in),
        .mem_to_reg_in   (mem_to_reg_in),
        .load_funct3_in  (load_funct3_in),
        .load_off_in     (load_off_in),
        .rf_ready        (rf_ready),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .align_err       (align_err),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m2r, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [2:0] f3, input logic [1:0] off);
        in_valid        = 1'b1;
        mem_to_reg_in   = m2r;
        rd_addr_in      = rd;
        reg_write_en_in = wen;
        alu_result_in   = alu;
        load_data_in    = ld;
        load_funct3_in  = f3;
        load_off_in     = off;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        in_valid        = 1'b0;
        alu_result_in   = '0;
        load_data_in    = '0;
        pc_plus4_in     = 32'h0000_1004;
        rd_addr_in      = '0;
        reg_write_en_in = 1'b0;
        mem_to_reg_in   = 2'b00;
        load_funct3_in  = 3'b000;
        load_off_in     = 2'd0;
        rf_ready        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rf_we", rf_we, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_align_err", align_err, 0);
        check("rst_count", retired_count, 0);
        check("rst_in_ready", in_ready, 1);

        // ALU write, visible one cycle after accept
        drive(2'b00, 5'd5, 1'b1, 32'h1234, 32'h0, 3'b000, 2'd0);
        tick();
        idle();
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 5);
        check("alu_wdata", rf_wdata, 32'h1234);
        check("alu_fwd_valid", fwd_valid, 1);
        check("alu_fwd_rd", fwd_rd, 5);
        check("alu_fwd_data", fwd_data, 32'h1234);
        tick();
        check("alu_count", retired_count, 1);
        check("alu_we_after", rf_we, 0);

        // Load formatting
        drive(2'b01, 5'd6, 1'b1, 32'h0, 32'h80FF_7F00, 3'b000, 2'd3);
        tick();
        idle();
        check("lb_data", rf_wdata, 32'hFFFF_FF80);
        tick();
        drive(2'b01, 5'd6, 1'b1, 32'h0, 32'h80FF_7F00, 3'b100, 2'd3);
        tick();
        idle();
        check("lbu_data", rf_wdata, 32'h0000_0080);
        tick();
        drive(2'b01, 5'd6, 1'b1, 32'h0, 32'h80FF_7F00, 3'b001, 2'd2);
        tick();
        idle();
        check("lh_data", rf_wdata, 32'hFFFF_80FF);
        check("lh_we", rf_we, 1);
        tick();
        check("load_count", retired_count, 4);

        // PC+4 source
        drive(2'b10, 5'd1, 1'b1, 32'h0, 32'h0, 3'b000, 2'd0);
        tick();
        idle();
        check("pc4_data", rf_wdata, 32'h0000_1004);
        tick();

        // Misaligned LW retires without writing and pulses align_err
        drive(2'b01, 5'd7, 1'b1, 32'h0, 32'hDEAD_BEEF, 3'b010, 2'd2);
        tick();
        idle();
        check("lw_mis_we", rf_we, 0);
        check("lw_mis_err_early", align_err, 0);
        tick();
        check("lw_mis_align_err", align_err, 1);
        check("lw_mis_count", retired_count, 6);
        tick();
        check("lw_mis_err_clear", align_err, 0);

        // rd=0 never writes
        drive(2'b00, 5'd0, 1'b1, 32'hAAAA, 32'h0, 3'b000, 2'd0);
        tick();
        idle();
        check("rd0_we", rf_we, 0);
        tick();
        check("rd0_count", retired_count, 7);
        check("rd0_align_err", align_err, 0);

        // Back-pressure: fill the FIFO with rf_ready low
        rf_ready = 1'b0;
        drive(2'b00, 5'd1, 1'b1, 32'h11, 32'h0, 3'b000, 2'd0);
        tick();
        check("bp_ready_1", in_ready, 1);
        drive(2'b00, 5'd2, 1'b1, 32'h22, 32'h0, 3'b000, 2'd0);
        tick();
        check("bp_full_ready", in_ready, 0);
        check("bp_head_rd", rf_waddr, 1);
        check("bp_fwd_data", fwd_data, 32'h11);
        drive(2'b00, 5'd3, 1'b1, 32'h33, 32'h0, 3'b000, 2'd0);
        tick();
        check("bp_stall_ready", in_ready, 0);
        check("bp_stall_rd", rf_waddr, 1);
        check("bp_stall_data", rf_wdata, 32'h11);
        rf_ready = 1'b1;
        tick();
        check("bp_head2_rd", fwd_rd, 2);
        check("bp_head2_data", rf_wdata, 32'h22);
        check("bp_ready_clear", in_ready, 1);
        check("bp_count_1", retired_count, 8);
        tick();
        idle();
        check("bp_head3_rd", rf_waddr, 3);
        check("bp_head3_data", fwd_data, 32'h33);
        check("bp_count_2", retired_count, 9);
        tick();
        check("bp_count_3", retired_count, 10);
        check("bp_empty_we", rf_we, 0);

        // Streaming with rf_ready=1: one retire per cycle, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(2'b00, 5'(i + 1), 1'b1, 32'h100 + 32'(i), 32'h0, 3'b000, 2'd0);
            tick();
            check("stream_rd", rf_waddr, 64'(i + 1));
            check("stream_data", rf_wdata, 64'(32'h100 + 32'(i)));
            check("stream_ready", in_ready, 1);
        end
        idle();
        tick();
        check("stream_count", retired_count, 20);
        check("stream_we_after", rf_we, 0);

        // Reset discards buffered entries
        rf_ready = 1'b0;
        drive(2'b00, 5'd8, 1'b1, 32'h88, 32'h0, 3'b000, 2'd0);
        tick();
        drive(2'b00, 5'd9, 1'b1, 32'h99, 32'h0, 3'b000, 2'd0);
        tick();
        idle();
        check("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_count", retired_count, 0);
        check("mid_rst_fwd", fwd_valid, 0);
        rf_ready = 1'b1;
        tick();
        tick();
        check("post_rst_we", rf_we, 0);
        check("post_rst_count", retired_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
